// File: rtl/afifo_rd_drain.sv
// Read-side drain stage for the async FIFO (rd_clk domain).
// Turns the FIFO's show-ahead empty/inc port into a valid/ready stream
// through a 2-entry skid buffer. Also provides enable gating, a flush
// sequence that discards everything pending, and delivered/dropped counters.
module afifo_rd_drain #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             en,
  input  logic             flush,
  input  logic [DSIZE-1:0] fifo_rd_data,
  input  logic             fifo_rd_empty,
  output logic             fifo_rd_inc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             flush_done,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int NENT = 2;

  state_t           r_state;
  logic [1:0]       r_occ;
  logic [DSIZE-1:0] r_buf [NENT];
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_hs;
  logic             w_flush_entry;
  logic             w_flush_exit;
  logic             w_pop_run;
  logic             w_pop_flush;
  logic             w_pop;
  logic [1:0]       w_occ_after_hs;
  logic [1:0]       w_occ_next;
  logic [1:0]       w_drop_inc;
  logic [CNT_W:0]   w_drop_sum;
  logic [CNT_W-1:0] w_drop_next;
  logic [DSIZE-1:0] w_shift [NENT];
  logic [DSIZE-1:0] w_buf_next [NENT];

  // The head entry is visible to the consumer; a handshake retires it this edge.
  assign w_hs = (r_occ != 2'd0) && m_ready;

  // Flush is only accepted outside FLUSH; re-assertion inside FLUSH is ignored.
  assign w_flush_entry = flush && (r_state != ST_FLUSH);
  assign w_flush_exit  = (r_state == ST_FLUSH) && fifo_rd_empty;

  // Entries still held after this cycle's handshake; also the tail write slot.
  assign w_occ_after_hs = r_occ - {1'b0, w_hs};

  // In RUN a pop is allowed when a slot is free now or is freed by the handshake.
  // The flush request cycle never pops, so nothing is captured that would be dropped.
  assign w_pop_run   = (r_state == ST_RUN) && !flush && !fifo_rd_empty &&
                       ((r_occ < 2'd2) || w_hs);
  assign w_pop_flush = (r_state == ST_FLUSH) && !fifo_rd_empty;
  // Reset suppresses pops so words left in the FIFO survive a reset.
  assign w_pop       = !rd_rst && (w_pop_run || w_pop_flush);

  assign w_occ_next = w_occ_after_hs + {1'b0, w_pop_run};

  // Each entry shifts toward the head on a handshake, then the popped word
  // lands in the first free slot counted after that shift.
  genvar gi;
  generate
    for (gi = 0; gi < NENT; gi++) begin : g_entry
      if (gi < NENT - 1) begin : g_shift
        assign w_shift[gi] = w_hs ? r_buf[gi+1] : r_buf[gi];
      end else begin : g_last
        assign w_shift[gi] = r_buf[gi];
      end
      assign w_buf_next[gi] = (w_pop_run && (w_occ_after_hs == 2'(gi))) ?
                              fifo_rd_data : w_shift[gi];
    end
  endgenerate

  // Drops: leftover buffer entries at flush entry, then one per FLUSH pop.
  assign w_drop_inc  = w_flush_entry ? w_occ_after_hs :
                       (w_pop_flush ? 2'd1 : 2'd0);
  assign w_drop_sum  = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};
  assign w_drop_next = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

  // Control FSM: IDLE/RUN follow en, flush overrides, FLUSH ends on an empty FIFO.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush)       r_state <= ST_FLUSH;
          else if (en)     r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (flush)       r_state <= ST_FLUSH;
          else if (!en)    r_state <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (fifo_rd_empty) r_state <= en ? ST_RUN : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Skid buffer storage and occupancy; flush entry empties it without touching data.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_occ <= 2'd0;
      for (int i = 0; i < NENT; i++) r_buf[i] <= '0;
    end else if (w_flush_entry || (r_state == ST_FLUSH)) begin
      r_occ <= 2'd0;
    end else begin
      r_occ <= w_occ_next;
      for (int i = 0; i < NENT; i++) r_buf[i] <= w_buf_next[i];
    end
  end

  // Delivered words wrap; dropped words saturate.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_word_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_hs) r_word_cnt <= r_word_cnt + 1'b1;
      r_drop_cnt <= w_drop_next;
    end
  end

  assign fifo_rd_inc = w_pop;
  assign m_valid     = (r_occ != 2'd0);
  assign m_data      = r_buf[0];
  assign busy        = (r_state == ST_FLUSH);
  assign flush_done  = w_flush_exit;
  assign word_cnt    = r_word_cnt;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Self-checking bench for afifo_rd_drain: a queue-based FIFO feeds the DUT
// and a queue-level reference model predicts the stream and counters.
module tb_afifo_rd_drain;

  localparam int DSIZE      = 8;
  localparam int CNT_W      = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int DROP_MAX   = (1 << CNT_W) - 1;

  logic             rd_clk = 1'b0;
  logic             rd_rst;
  logic             en;
  logic             flush;
  logic [DSIZE-1:0] fifo_rd_data;
  logic             fifo_rd_empty;
  logic             fifo_rd_inc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             busy;
  logic             flush_done;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] drop_cnt;

  always #5 rd_clk = ~rd_clk;

  afifo_rd_drain #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .en(en), .flush(flush),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_inc(fifo_rd_inc), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .flush_done(flush_done),
    .word_cnt(word_cnt), .drop_cnt(drop_cnt)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // FIFO contents and the words popped into the DUT but not yet delivered
  logic [DSIZE-1:0] fq [$];
  logic [DSIZE-1:0] exp_q [$];
  bit               model_ok = 1'b0;
  bit               m_run    = 1'b0;
  bit               flushing = 1'b0;
  logic [CNT_W-1:0] word_exp = '0;
  int               drop_exp = 0;
  int               pop_total = 0;
  int               done_pulses = 0;

  function automatic void fifo_update();
    fifo_rd_empty = (fq.size() == 0);
    fifo_rd_data  = (fq.size() == 0) ? '0 : fq[0];
  endfunction

  task automatic push_word(input logic [DSIZE-1:0] w);
    fq.push_back(w);
    fifo_update();
  endtask

  // One clock cycle: predict and compare at the falling edge, pop the FIFO after the rising edge.
  task automatic step();
    bit exp_valid, hs, exp_inc, inc_s, empty_s, exp_done;
    logic [CNT_W-1:0] drop_ref;
    @(negedge rd_clk);
    inc_s   = fifo_rd_inc;
    empty_s = (fq.size() == 0);
    exp_valid = !flushing && (exp_q.size() != 0);
    hs        = exp_valid && m_ready;
    if (rd_rst)        exp_inc = 1'b0;
    else if (flushing) exp_inc = !empty_s;
    else if (flush)    exp_inc = 1'b0;
    else               exp_inc = m_run && !empty_s && ((exp_q.size() < 2) || hs);
    exp_done = flushing && empty_s;
    drop_ref = CNT_W'((drop_exp > DROP_MAX) ? DROP_MAX : drop_exp);
    if (model_ok) begin
      vec_cnt++;
      if (word_cnt !== word_exp) begin
        err_cnt++; $display("FAIL word_cnt: got %0d expected %0d", word_cnt, word_exp);
      end
      vec_cnt++;
      if (drop_cnt !== drop_ref) begin
        err_cnt++; $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, drop_ref);
      end
      vec_cnt++;
      if (m_valid !== exp_valid) begin
        err_cnt++; $display("FAIL m_valid: got %b expected %b", m_valid, exp_valid);
      end
      if (exp_valid) begin
        vec_cnt++;
        if (m_data !== exp_q[0]) begin
          err_cnt++; $display("FAIL m_data: got %h expected %h", m_data, exp_q[0]);
        end
      end
      vec_cnt++;
      if (fifo_rd_inc !== exp_inc) begin
        err_cnt++; $display("FAIL fifo_rd_inc: got %b expected %b (empty=%b)", fifo_rd_inc, exp_inc, empty_s);
      end
      vec_cnt++;
      if (busy !== flushing) begin
        err_cnt++; $display("FAIL busy: got %b expected %b", busy, flushing);
      end
      vec_cnt++;
      if (flush_done !== exp_done) begin
        err_cnt++; $display("FAIL flush_done: got %b expected %b", flush_done, exp_done);
      end
    end
    if (inc_s) pop_total++;
    if (flush_done === 1'b1) done_pulses++;
    if (rd_rst) begin
      exp_q.delete();
      flushing = 1'b0;
      m_run    = 1'b0;
      word_exp = '0;
      drop_exp = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (hs) begin
        $display("deliver %h (word %0d)", exp_q[0], word_exp);
        void'(exp_q.pop_front());
        word_exp = word_exp + 1'b1;
      end
      if (flushing) begin
        if (exp_inc) drop_exp++;
        if (empty_s) begin
          flushing = 1'b0;
          m_run    = en;
        end
      end else if (flush) begin
        drop_exp += exp_q.size();
        exp_q.delete();
        flushing = 1'b1;
      end else begin
        if (exp_inc) exp_q.push_back(fq[0]);
        m_run = en;
      end
    end
    @(posedge rd_clk);
    #1;
    if (inc_s && (fq.size() != 0)) void'(fq.pop_front());
    fifo_update();
  endtask

  task automatic do_reset(input bit clear_fifo);
    if (clear_fifo) begin
      fq.delete();
      fifo_update();
    end
    rd_rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    step();
    step();
    rd_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
    vec_cnt++; if (m_data !== '0) begin err_cnt++; $display("FAIL rst_m_data: got %h expected 00", m_data); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vec_cnt++; if (flush_done !== 1'b0) begin err_cnt++; $display("FAIL rst_flush_done: got %b expected 0", flush_done); end
    vec_cnt++; if (word_cnt !== '0) begin err_cnt++; $display("FAIL rst_word_cnt: got %0d expected 0", word_cnt); end
    vec_cnt++; if (drop_cnt !== '0) begin err_cnt++; $display("FAIL rst_drop_cnt: got %0d expected 0", drop_cnt); end
    vec_cnt++; if (fifo_rd_inc !== 1'b0) begin err_cnt++; $display("FAIL rst_inc: got %b expected 0", fifo_rd_inc); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset(1'b1);
    en = 1'b1; m_ready = 1'b1;
    step();
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    step();
    vec_cnt++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin err_cnt++; $display("FAIL basic_w0: got v=%b d=%h expected v=1 d=11", m_valid, m_data); end
    step();
    vec_cnt++; if (m_valid !== 1'b1 || m_data !== 8'h22) begin err_cnt++; $display("FAIL basic_w1: got v=%b d=%h expected v=1 d=22", m_valid, m_data); end
    step();
    vec_cnt++; if (m_valid !== 1'b1 || m_data !== 8'h33) begin err_cnt++; $display("FAIL basic_w2: got v=%b d=%h expected v=1 d=33", m_valid, m_data); end
    step();
    vec_cnt++; if (word_cnt !== 16'd3) begin err_cnt++; $display("FAIL basic_cnt: got %0d expected 3", word_cnt); end
    vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_idle: got %b expected 0", m_valid); end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    logic [DSIZE-1:0] w [8];
    int p0;
    do_reset(1'b1);
    en = 1'b1; m_ready = 1'b0;
    step();
    p0 = pop_total;
    for (int i = 0; i < 8; i++) begin
      w[i] = DSIZE'($urandom);
      push_word(w[i]);
    end
    repeat (6) step();
    vec_cnt++; if (pop_total - p0 !== 2) begin err_cnt++; $display("FAIL bp_pops: got %0d expected 2", pop_total - p0); end
    vec_cnt++; if (fq.size() !== 6) begin err_cnt++; $display("FAIL bp_fifo_left: got %0d expected 6", fq.size()); end
    vec_cnt++; if (m_valid !== 1'b1 || m_data !== w[0]) begin err_cnt++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, w[0]); end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vec_cnt++;
      if (m_valid !== 1'b1 || m_data !== w[i]) begin
        err_cnt++; $display("FAIL bp_stream%0d: got v=%b d=%h expected v=1 d=%h", i, m_valid, m_data, w[i]);
      end
      step();
    end
    vec_cnt++; if (word_cnt !== 16'd8) begin err_cnt++; $display("FAIL bp_cnt: got %0d expected 8", word_cnt); end
    vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_drained: got %b expected 0", m_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_disable();
    int p0;
    do_reset(1'b1);
    en = 1'b1; m_ready = 1'b0;
    step();
    for (int i = 0; i < 6; i++) push_word(DSIZE'($urandom));
    repeat (3) step();
    en = 1'b0;
    step();
    p0 = pop_total;
    m_ready = 1'b1;
    repeat (4) step();
    vec_cnt++; if (pop_total !== p0) begin err_cnt++; $display("FAIL dis_pops: got %0d expected %0d", pop_total, p0); end
    vec_cnt++; if (fq.size() !== 4) begin err_cnt++; $display("FAIL dis_fifo_left: got %0d expected 4", fq.size()); end
    vec_cnt++; if (word_cnt !== 16'd2) begin err_cnt++; $display("FAIL dis_cnt: got %0d expected 2", word_cnt); end
    vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL dis_valid: got %b expected 0", m_valid); end
    $display("test_disable done");
  endtask

  task automatic test_flush();
    int d0;
    do_reset(1'b1);
    en = 1'b1; m_ready = 1'b0;
    step();
    for (int i = 0; i < 7; i++) push_word(DSIZE'($urandom));
    repeat (2) step();
    m_ready = 1'b1; flush = 1'b1;
    d0 = done_pulses;
    step();
    flush = 1'b0;
    vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL fl_valid: got %b expected 0", m_valid); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL fl_busy: got %b expected 1", busy); end
    vec_cnt++; if (word_cnt !== 16'd1) begin err_cnt++; $display("FAIL fl_word: got %0d expected 1", word_cnt); end
    vec_cnt++; if (drop_cnt !== 16'd1) begin err_cnt++; $display("FAIL fl_drop_entry: got %0d expected 1", drop_cnt); end
    for (int i = 0; i < 10; i++) begin
      flush = (i == 1);
      step();
    end
    flush = 1'b0;
    vec_cnt++; if (drop_cnt !== 16'd6) begin err_cnt++; $display("FAIL fl_drop: got %0d expected 6", drop_cnt); end
    vec_cnt++; if (done_pulses - d0 !== 1) begin err_cnt++; $display("FAIL fl_done_pulses: got %0d expected 1", done_pulses - d0); end
    vec_cnt++; if (fq.size() !== 0) begin err_cnt++; $display("FAIL fl_fifo_left: got %0d expected 0", fq.size()); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL fl_busy_end: got %b expected 0", busy); end
    $display("test_flush done");
  endtask

  task automatic test_flush_empty();
    int d0;
    do_reset(1'b1);
    d0 = done_pulses;
    flush = 1'b1;
    step();
    flush = 1'b0;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL fe_busy: got %b expected 1", busy); end
    step();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL fe_busy_end: got %b expected 0", busy); end
    vec_cnt++; if (drop_cnt !== '0) begin err_cnt++; $display("FAIL fe_drop: got %0d expected 0", drop_cnt); end
    step();
    vec_cnt++; if (done_pulses - d0 !== 1) begin err_cnt++; $display("FAIL fe_done_pulses: got %0d expected 1", done_pulses - d0); end
    $display("test_flush_empty done");
  endtask

  task automatic test_rst_flush();
    int p0;
    do_reset(1'b1);
    en = 1'b1; m_ready = 1'b0;
    step();
    for (int i = 0; i < 8; i++) push_word(DSIZE'($urandom));
    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    vec_cnt++; if (fq.size() !== 3) begin err_cnt++; $display("FAIL rf_pre_left: got %0d expected 3", fq.size()); end
    rd_rst = 1'b1; en = 1'b0;
    step();
    rd_rst = 1'b0;
    vec_cnt++; if (m_valid !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0) begin err_cnt++; $display("FAIL rf_ctrl: got v=%b b=%b d=%b expected 0 0 0", m_valid, busy, flush_done); end
    vec_cnt++; if (drop_cnt !== '0 || word_cnt !== '0) begin err_cnt++; $display("FAIL rf_cnts: got drop=%0d word=%0d expected 0 0", drop_cnt, word_cnt); end
    vec_cnt++; if (m_data !== '0) begin err_cnt++; $display("FAIL rf_data: got %h expected 00", m_data); end
    p0 = pop_total;
    repeat (4) step();
    vec_cnt++; if (pop_total !== p0) begin err_cnt++; $display("FAIL rf_no_pop: got %0d expected %0d", pop_total, p0); end
    vec_cnt++; if (fq.size() !== 3) begin err_cnt++; $display("FAIL rf_left: got %0d expected 3", fq.size()); end
    en = 1'b1; m_ready = 1'b1;
    repeat (6) step();
    vec_cnt++; if (word_cnt !== 16'd3 || fq.size() !== 0) begin err_cnt++; $display("FAIL rf_resume: got word=%0d left=%0d expected 3 0", word_cnt, fq.size()); end
    $display("test_rst_flush done");
  endtask

  task automatic test_random();
    do_reset(1'b1);
    for (int c = 0; c < 600; c++) begin
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1 && fq.size() < FIFO_DEPTH) push_word(DSIZE'($urandom));
      step();
    end
    flush = 1'b0; en = 1'b1; m_ready = 1'b1;
    repeat (40) step();
    vec_cnt++; if (fq.size() !== 0 || m_valid !== 1'b0) begin err_cnt++; $display("FAIL rnd_drain: got left=%0d v=%b expected 0 0", fq.size(), m_valid); end
    vec_cnt++; if (word_cnt !== word_exp) begin err_cnt++; $display("FAIL rnd_words: got %0d expected %0d", word_cnt, word_exp); end
    $display("test_random done: %0d words delivered, %0d dropped", word_exp, drop_exp);
  endtask

  initial begin
    rd_rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_update();
    @(posedge rd_clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_disable();
    test_flush();
    test_flush_empty();
    test_rst_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
